// File: rtl/regfile_access_sequencer.sv
// Serialises operand reads and buffered writebacks onto a single-port-per-cycle register file.
// Read latency: request accepted at edge N, operands valid in cycle N+3.
// Backpressure: rd_req_ready only in IDLE; wb_ready drops when the writeback FIFO is full; HOLD waits on op_ready.
module regfile_access_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int WB_DEPTH   = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  input  logic [ADDR_WIDTH-1:0] rd_addr2,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [DATA_WIDTH-1:0] op_data1,
  output logic [DATA_WIDTH-1:0] op_data2,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  RF_READ,
  output logic                  RF_WRITE,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_R1,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_R2,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_W,
  output logic [DATA_WIDTH-1:0] RF_DATA_W,
  input  logic [DATA_WIDTH-1:0] RF_DATA_R1,
  input  logic [DATA_WIDTH-1:0] RF_DATA_R2,
  output logic                  busy
);

  localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_READ    = 3'd2,
    S_CAPTURE = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] fifo_addr [WB_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [WB_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;

  logic                  enq, deq, take;
  logic                  fifo_full, fifo_empty;
  logic [ADDR_WIDTH-1:0] lat_addr1, lat_addr2;
  logic [DATA_WIDTH-1:0] fwd1, fwd2;
  logic [PTR_W-1:0]      idx;

  assign wb_ready   = (count < CNT_W'(WB_DEPTH));
  assign fifo_full  = ~wb_ready;
  assign fifo_empty = (count == '0);
  // Writes to register 0 complete the handshake but are dropped here.
  assign enq        = wb_valid & wb_ready & (wb_addr != '0);
  assign busy       = (state != S_IDLE) | ~fifo_empty;

  // Writeback FIFO storage; contents are qualified by count so need no reset.
  always_ff @(posedge CLK) begin
    if (enq) begin
      fifo_addr[wr_ptr] <= wb_addr;
      fifo_data[wr_ptr] <= wb_data;
    end
  end

  // Writeback FIFO pointers and occupancy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Forwarding: walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd1 = RF_DATA_R1;
    fwd2 = RF_DATA_R2;
    idx  = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (CNT_W'(i) < count) begin
        if (fifo_addr[idx] == lat_addr1) fwd1 = fifo_data[idx];
        if (fifo_addr[idx] == lat_addr2) fwd2 = fifo_data[idx];
      end
    end
    if (lat_addr1 == '0) fwd1 = '0;
    if (lat_addr2 == '0) fwd2 = '0;
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and register-file / handshake outputs.
  always_comb begin
    state_nxt    = state;
    rd_req_ready = 1'b0;
    op_valid     = 1'b0;
    RF_READ      = 1'b0;
    RF_WRITE     = 1'b0;
    RF_ADDR_R1   = '0;
    RF_ADDR_R2   = '0;
    RF_ADDR_W    = '0;
    RF_DATA_W    = '0;
    deq          = 1'b0;
    take         = 1'b0;
    case (state)
      S_IDLE: begin
        // A full FIFO must drain before another read so writes cannot starve.
        if (fifo_full) begin
          state_nxt = S_WRITE;
        end else if (rd_req_valid) begin
          rd_req_ready = 1'b1;
          take         = 1'b1;
          state_nxt    = S_READ;
        end else if (!fifo_empty) begin
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        RF_WRITE  = 1'b1;
        RF_ADDR_W = fifo_addr[rd_ptr];
        RF_DATA_W = fifo_data[rd_ptr];
        deq       = 1'b1;
        state_nxt = S_IDLE;
      end
      S_READ: begin
        RF_READ    = 1'b1;
        RF_ADDR_R1 = lat_addr1;
        RF_ADDR_R2 = lat_addr2;
        state_nxt  = S_CAPTURE;
      end
      S_CAPTURE: begin
        RF_READ    = 1'b1;
        RF_ADDR_R1 = lat_addr1;
        RF_ADDR_R2 = lat_addr2;
        state_nxt  = S_HOLD;
      end
      S_HOLD: begin
        op_valid = 1'b1;
        if (op_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Latched read addresses and captured operands.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lat_addr1 <= '0;
      lat_addr2 <= '0;
      op_data1  <= '0;
      op_data2  <= '0;
    end else begin
      if (take) begin
        lat_addr1 <= rd_addr1;
        lat_addr2 <= rd_addr2;
      end
      if (state == S_CAPTURE) begin
        op_data1 <= fwd1;
        op_data2 <= fwd2;
      end
    end
  end

endmodule

// File: tb/tb_regfile_access_sequencer.sv
module tb_regfile_access_sequencer;

  logic        CLK, RST;
  logic        rd_req_valid, rd_req_ready;
  logic [4:0]  rd_addr1, rd_addr2;
  logic        op_valid, op_ready;
  logic [31:0] op_data1, op_data2;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        RF_READ, RF_WRITE;
  logic [4:0]  RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W;
  logic [31:0] RF_DATA_W, RF_DATA_R1, RF_DATA_R2;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int both_cnt = 0;
  int zero_wr = 0;

  // Register file model: combinational read, write on posedge.
  logic [31:0] mem [32];
  logic        load_mem;

  regfile_access_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WB_DEPTH(2)) dut (
    .CLK(CLK), .RST(RST),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_data1(op_data1), .op_data2(op_data2),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data),
    .RF_READ(RF_READ), .RF_WRITE(RF_WRITE),
    .RF_ADDR_R1(RF_ADDR_R1), .RF_ADDR_R2(RF_ADDR_R2), .RF_ADDR_W(RF_ADDR_W),
    .RF_DATA_W(RF_DATA_W), .RF_DATA_R1(RF_DATA_R1), .RF_DATA_R2(RF_DATA_R2),
    .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Register file storage: preload, then take writes.
  always @(posedge CLK) begin
    if (load_mem) begin
      for (int i = 0; i < 32; i++) mem[i] <= (i == 0) ? 32'hBAD0_0000 : (32'h1000_0000 | i);
    end else if (RF_WRITE) begin
      mem[RF_ADDR_W] <= RF_DATA_W;
    end
  end

  assign RF_DATA_R1 = RF_READ ? mem[RF_ADDR_R1] : 32'h0;
  assign RF_DATA_R2 = RF_READ ? mem[RF_ADDR_R2] : 32'h0;

  // Protocol monitors.
  always @(posedge CLK) begin
    if (RF_READ && RF_WRITE) both_cnt <= both_cnt + 1;
    if (RF_WRITE && RF_ADDR_W == 5'd0) zero_wr <= zero_wr + 1;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rv;
    logic [4:0]  a1, a2;
    logic        ordy, wv;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        e_rrdy, e_ovld, e_rd, e_wr;
    logic [4:0]  e_ar1, e_aw;
    logic [31:0] e_dw;
    logic        e_wbrdy, e_busy;
    logic [31:0] e_d1, e_d2;
  } vec_t;

  function automatic vec_t mk(
    input logic rv, input logic [4:0] a1, input logic [4:0] a2, input logic ordy,
    input logic wv, input logic [4:0] wa, input logic [31:0] wd,
    input logic e_rrdy, input logic e_ovld, input logic e_rd, input logic e_wr,
    input logic [4:0] e_ar1, input logic [4:0] e_aw, input logic [31:0] e_dw,
    input logic e_wbrdy, input logic e_busy, input logic [31:0] e_d1, input logic [31:0] e_d2);
    vec_t v;
    v.rv = rv; v.a1 = a1; v.a2 = a2; v.ordy = ordy; v.wv = wv; v.wa = wa; v.wd = wd;
    v.e_rrdy = e_rrdy; v.e_ovld = e_ovld; v.e_rd = e_rd; v.e_wr = e_wr;
    v.e_ar1 = e_ar1; v.e_aw = e_aw; v.e_dw = e_dw;
    v.e_wbrdy = e_wbrdy; v.e_busy = e_busy; v.e_d1 = e_d1; v.e_d2 = e_d2;
    return v;
  endfunction

  localparam int NV = 25;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;
  localparam logic [31:0] M3 = 32'h1000_0003;

  vec_t vt [NV];
  logic [116:0] rst_exp;
  int n;

  initial begin
    // rv a1 a2 ordy wv wa wd | rrdy ovld rd wr ar1 aw dw wbrdy busy d1 d2
    vt[0]  = mk(0,0,0,0, 0,0,0,      0,0,0,0, 0,0,0,      1,0, 0,0);
    vt[1]  = mk(0,0,0,0, 1,5,DB,     0,0,0,0, 0,0,0,      1,0, 0,0);
    vt[2]  = mk(0,0,0,0, 0,0,0,      0,0,0,0, 0,0,0,      1,1, 0,0);
    vt[3]  = mk(0,0,0,0, 0,0,0,      0,0,0,1, 0,5,DB,     1,1, 0,0);
    vt[4]  = mk(1,5,0,0, 0,0,0,      1,0,0,0, 0,0,0,      1,0, 0,0);
    vt[5]  = mk(0,0,0,0, 0,0,0,      0,0,1,0, 5,0,0,      1,1, 0,0);
    vt[6]  = mk(0,0,0,0, 0,0,0,      0,0,1,0, 5,0,0,      1,1, 0,0);
    vt[7]  = mk(0,0,0,0, 0,0,0,      0,1,0,0, 0,0,0,      1,1, DB,0);
    vt[8]  = mk(0,0,0,1, 0,0,0,      0,1,0,0, 0,0,0,      1,1, DB,0);
    vt[9]  = mk(1,7,3,0, 1,7,32'h11, 1,0,0,0, 0,0,0,      1,0, DB,0);
    vt[10] = mk(0,0,0,0, 1,7,32'h22, 0,0,1,0, 7,0,0,      1,1, DB,0);
    vt[11] = mk(0,0,0,0, 0,0,0,      0,0,1,0, 7,0,0,      0,1, DB,0);
    vt[12] = mk(0,0,0,1, 0,0,0,      0,1,0,0, 0,0,0,      0,1, 32'h22,M3);
    vt[13] = mk(1,7,7,0, 0,0,0,      0,0,0,0, 0,0,0,      0,1, 32'h22,M3);
    vt[14] = mk(1,7,7,0, 0,0,0,      0,0,0,1, 0,7,32'h11, 0,1, 32'h22,M3);
    vt[15] = mk(1,7,7,0, 0,0,0,      1,0,0,0, 0,0,0,      1,1, 32'h22,M3);
    vt[16] = mk(0,0,0,0, 0,0,0,      0,0,1,0, 7,0,0,      1,1, 32'h22,M3);
    vt[17] = mk(0,0,0,0, 0,0,0,      0,0,1,0, 7,0,0,      1,1, 32'h22,M3);
    vt[18] = mk(0,0,0,1, 0,0,0,      0,1,0,0, 0,0,0,      1,1, 32'h22,32'h22);
    vt[19] = mk(0,0,0,0, 0,0,0,      0,0,0,0, 0,0,0,      1,1, 32'h22,32'h22);
    vt[20] = mk(0,0,0,0, 0,0,0,      0,0,0,1, 0,7,32'h22, 1,1, 32'h22,32'h22);
    vt[21] = mk(0,0,0,0, 0,0,0,      0,0,0,0, 0,0,0,      1,0, 32'h22,32'h22);
    vt[22] = mk(0,0,0,0, 1,0,32'hFFFF,0,0,0,0,0,0,0,      1,0, 32'h22,32'h22);
    vt[23] = mk(0,0,0,0, 0,0,0,      0,0,0,0, 0,0,0,      1,0, 32'h22,32'h22);
    vt[24] = mk(0,0,0,0, 0,0,0,      0,0,0,0, 0,0,0,      1,0, 32'h22,32'h22);

    rst_exp = {1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0};

    RST = 1'b1; load_mem = 1'b1;
    rd_req_valid = 0; rd_addr1 = 0; rd_addr2 = 0; op_ready = 0;
    wb_valid = 0; wb_addr = 0; wb_data = 0;
    @(negedge CLK);
    @(negedge CLK);
    load_mem = 1'b0;
    #1;
    chk("reset_state", {RF_WRITE, RF_READ, RF_ADDR_W, RF_DATA_W, RF_ADDR_R1, RF_ADDR_R2,
                        rd_req_ready, op_valid, busy, wb_ready, op_data1, op_data2}, rst_exp);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Cycle-by-cycle vectors: write-then-read, forwarding, full-FIFO priority, address 0.
    for (int i = 0; i < NV; i++) begin
      rd_req_valid = vt[i].rv; rd_addr1 = vt[i].a1; rd_addr2 = vt[i].a2;
      op_ready = vt[i].ordy; wb_valid = vt[i].wv; wb_addr = vt[i].wa; wb_data = vt[i].wd;
      #1;
      chk($sformatf("vec%0d", i),
          {rd_req_ready, op_valid, RF_READ, RF_WRITE, RF_ADDR_R1, RF_ADDR_W, RF_DATA_W,
           wb_ready, busy, op_data1, op_data2},
          {vt[i].e_rrdy, vt[i].e_ovld, vt[i].e_rd, vt[i].e_wr, vt[i].e_ar1, vt[i].e_aw, vt[i].e_dw,
           vt[i].e_wbrdy, vt[i].e_busy, vt[i].e_d1, vt[i].e_d2});
      @(negedge CLK);
    end
    rd_req_valid = 0; op_ready = 0; wb_valid = 0;
    chk("rf_reg7_after_drain", mem[7], 32'h22);
    chk("rf_reg5", mem[5], DB);

    // Reset asserted in the middle of a WRITE abandons it.
    wb_valid = 1; wb_addr = 5'd9; wb_data = 32'h99;
    @(negedge CLK);
    wb_valid = 0;
    @(negedge CLK);
    #1;
    chk("pre_reset_write", {RF_WRITE, RF_ADDR_W}, {1'b1, 5'd9});
    RST = 1'b1;
    #1;
    chk("reset_mid_write", {RF_WRITE, RF_READ, RF_ADDR_W, RF_DATA_W, RF_ADDR_R1, RF_ADDR_R2,
                            rd_req_ready, op_valid, busy, wb_ready, op_data1, op_data2}, rst_exp);
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_rf_unchanged", {busy, mem[9]}, {1'b0, 32'h1000_0009});

    // Back-pressure: fill FIFO while a read sits in HOLD.
    rd_req_valid = 1; rd_addr1 = 5'd1; rd_addr2 = 5'd2;
    @(negedge CLK);
    rd_req_valid = 0;
    @(negedge CLK);
    @(negedge CLK);
    wb_valid = 1; wb_addr = 5'd10; wb_data = 32'hA;
    @(negedge CLK);
    wb_addr = 5'd11; wb_data = 32'hB;
    @(negedge CLK);
    wb_valid = 0;
    #1;
    chk("bp_full_hold", {wb_ready, op_valid, op_data1, op_data2}, {1'b0, 1'b1, 32'h1000_0001, 32'h1000_0002});
    rd_req_valid = 1; rd_addr1 = 5'd10; rd_addr2 = 5'd11; op_ready = 1;
    #1;
    chk("bp_no_accept_in_hold", rd_req_ready, 1'b0);
    @(negedge CLK);
    op_ready = 0;
    #1;
    chk("bp_idle_full", {rd_req_ready, RF_WRITE, busy}, {1'b0, 1'b0, 1'b1});
    @(negedge CLK);
    #1;
    chk("bp_write_first", {rd_req_ready, RF_WRITE, RF_ADDR_W, RF_DATA_W}, {1'b0, 1'b1, 5'd10, 32'hA});
    @(negedge CLK);
    #1;
    chk("bp_read_wins", {rd_req_ready, RF_WRITE}, {1'b1, 1'b0});
    // Latency from acceptance to op_valid.
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      rd_req_valid = 0;
      n++;
      #1;
      if (op_valid) break;
    end
    chk("bp_latency", n, 3);
    chk("bp_operands", {op_valid, op_data1, op_data2}, {1'b1, 32'hA, 32'hB});

    // Stall: op_ready low for 10 cycles with a request pending.
    rd_req_valid = 1; rd_addr1 = 5'd1; rd_addr2 = 5'd2;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("stall%0d", k), {op_valid, rd_req_ready, op_data1, op_data2},
          {1'b1, 1'b0, 32'hA, 32'hB});
      @(negedge CLK);
    end
    op_ready = 1;
    @(negedge CLK);
    #1;
    chk("stall_release_idle", {op_valid, rd_req_ready}, {1'b0, 1'b1});
    @(negedge CLK);
    rd_req_valid = 0;
    n = 0;
    while (busy && n < 30) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_timeout", busy, 1'b0);
    chk("drain_contents", {mem[10], mem[11], op_data1, op_data2},
        {32'hA, 32'hB, 32'h1000_0001, 32'h1000_0002});

    chk("never_read_and_write", both_cnt, 0);
    chk("never_write_reg0", zero_wr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_access_sequencer.md
Name: regfile_access_sequencer

Overview:
- Sits between decode/writeback and REGISTER_FILE_32x32, which cannot read and write in the same cycle.
- Serialises operand reads and result writes onto its READ/WRITE/ADDR/DATA ports.
- Buffers pending writebacks in a small FIFO and forwards buffered data to reads, so reads always see the newest value.
- Read operands are returned to the downstream stage over a valid/ready handshake.

Parameters:
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register address width (32 registers)
- WB_DEPTH, 2, writeback FIFO entries (power of 2, >=2)

Ports:
- CLK  in  1  clock; all state updates on posedge
- RST  in  1  reset, asynchronous, active-high
- rd_req_valid  in  1  operand read request valid
- rd_req_ready  out  1  read request accepted this cycle
- rd_addr1, rd_addr2  in  ADDR_WIDTH  operand register addresses
- op_valid  out  1  operands valid
- op_ready  in  1  downstream takes operands
- op_data1, op_data2  out  DATA_WIDTH  operand values
- wb_valid  in  1  writeback request valid
- wb_ready  out  1  writeback FIFO not full
- wb_addr  in  ADDR_WIDTH  writeback destination register
- wb_data  in  DATA_WIDTH  writeback value
- RF_READ, RF_WRITE  out  1  register file READ / WRITE
- RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W  out  ADDR_WIDTH  register file addresses
- RF_DATA_W  out  DATA_WIDTH  register file write data
- RF_DATA_R1, RF_DATA_R2  in  DATA_WIDTH  register file read data
- busy  out  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Reset (RST=1, async):
  - FSM goes to IDLE and the FIFO empties.
  - All outputs are 0 except wb_ready=1.
  - Operand registers clear to 0.
  - Takes effect immediately, mid-operation included; an in-flight read or write is abandoned.
- Writeback FIFO:
  - wb_ready = (count < WB_DEPTH), a registered count.
  - An entry is enqueued on the edge where wb_valid & wb_ready.
  - wb_addr==0 is accepted (handshake completes) but not enqueued; register 0 is never written.
  - Enqueue and dequeue on the same edge leave count unchanged.
- FSM states: IDLE, WRITE, READ, CAPTURE, HOLD. RF_READ and RF_WRITE are never both 1.
  - IDLE:
    - If FIFO full, go to WRITE.
    - Else if rd_req_valid: rd_req_ready=1; latch rd_addr1/2; go to READ.
    - Else if FIFO non-empty, go to WRITE.
    - Else stay.
    - All decisions use count at the start of the cycle, so reads win over writes unless the FIFO is full.
  - WRITE:
    - RF_WRITE=1, RF_READ=0.
    - RF_ADDR_W/RF_DATA_W = FIFO head; head pops on the edge.
    - Always goes to IDLE; exactly one write per visit.
  - READ:
    - RF_READ=1, RF_WRITE=0.
    - RF_ADDR_R1/R2 = latched addresses.
    - Goes to CAPTURE.
  - CAPTURE:
    - RF_READ stays 1 with the same addresses.
    - On the edge, op_data1/2 load RF_DATA_R1/R2, overridden by the youngest FIFO entry with a matching address.
    - Forwarding covers entries resident during the CAPTURE cycle; an entry enqueued on the capture edge is not visible.
    - Address 0 yields 0.
    - Goes to HOLD.
  - HOLD:
    - op_valid=1; op_data stable.
    - When op_ready, go to IDLE.
    - A new request is not accepted in HOLD.
- Outputs RF_ADDR_*/RF_DATA_W are 0 when not used by the current state.
- Latency: request accepted at edge N → op_valid asserted in cycle N+3 (READ at N+1, CAPTURE at N+2).
- Starvation: a full FIFO forces a WRITE before the next read, so a continuous read stream still drains one write per read.
- rd_req_ready=0 in every state except IDLE.

Test Plan:
1. Reset: pulse RST mid-WRITE → RF_WRITE drops to 0 immediately, busy=0, wb_ready=1, op_valid=0; RF contents unchanged.
2. Write then read:
   - wb (addr 5, 0xDEADBEEF) with no read pending → RF_WRITE with ADDR_W=5 one cycle later.
   - Then read rd_addr1=5, rd_addr2=0 → op_data1=0xDEADBEEF, op_data2=0; op_valid in cycle N+3.
3. Forwarding:
   - Enqueue (7, 0x11) then (7, 0x22) while rd_req_valid is held with rd_addr1=7.
   - Read wins over both writes → op_data1=0x22 (youngest), no RF write has occurred yet.
4. Back-pressure:
   - Fill the FIFO with 2 entries while a read is in HOLD with op_ready=0 → wb_ready=0.
   - Release op_ready → FSM enters WRITE before accepting the next pending read.
5. Address 0: wb (0, 0xFFFF) → wb handshake completes, count stays 0, RF_WRITE never asserts.
6. Stall: op_ready=0 for 10 cycles → op_valid and op_data stable, rd_req_ready=0; op_ready=1 → IDLE next cycle.
